// File: rtl/load_store_unit.sv
// Data-side load/store stage: byte/half/word loads with extension, sub-word stores via read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN enables misaligned-address error reporting.
module load_store_unit #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] rdata,
  output logic                wen,
  output logic [WORD_LEN-1:0] wdata
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RESP} state_t;

  state_t              state, state_n;
  logic [1:0]          off_q, off_n;
  logic [2:0]          funct3_q, funct3_n;
  logic                store_q, store_n;
  logic [WORD_LEN-1:0] sdata_q, sdata_n;
  logic                resp_valid_n, resp_err_n, wen_n;
  logic [WORD_LEN-1:0] resp_rdata_n, d_addr_n, wdata_n;

  logic                illegal, misalign, req_err;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [WORD_LEN-1:0] load_val, merged;

  assign req_ready = (state == IDLE);

  always_comb begin
    if (req_wen) illegal = (req_funct3 > 3'd2);
    else         illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    req_err = illegal | misalign;
  end

  // Lane selection; offsets below the access size are ignored (only matters when unchecked)
  always_comb begin
    case (off_q)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = off_q[1] ? rdata[31:16] : rdata[15:0];
    case (funct3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd2:    load_val = rdata;
      3'd4:    load_val = {24'd0, lane_b};
      3'd5:    load_val = {16'd0, lane_h};
      default: load_val = '0;
    endcase
    merged = rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (off_q)
        2'd0:    merged[7:0]   = sdata_q[7:0];
        2'd1:    merged[15:8]  = sdata_q[7:0];
        2'd2:    merged[23:16] = sdata_q[7:0];
        default: merged[31:24] = sdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = sdata_q[15:0];
    end else begin
      merged[15:0] = sdata_q[15:0];
    end
  end

  always_comb begin
    state_n      = state;
    off_n        = off_q;
    funct3_n     = funct3_q;
    store_n      = store_q;
    sdata_n      = sdata_q;
    resp_valid_n = 1'b0;
    resp_err_n   = 1'b0;
    resp_rdata_n = resp_rdata;
    d_addr_n     = d_addr;
    wen_n        = 1'b0;
    wdata_n      = wdata;
    case (state)
      IDLE: if (req_valid) begin
        off_n    = req_addr[1:0];
        funct3_n = req_funct3;
        store_n  = req_wen;
        sdata_n  = req_wdata;
        d_addr_n = {req_addr[WORD_LEN-1:2], 2'b00};
        if (req_err) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
          resp_rdata_n = '0;
        end else if (req_wen && req_funct3 == 3'd2) begin
          state_n = WRITE;
          wen_n   = 1'b1;
          wdata_n = req_wdata;
        end else begin
          state_n = ADDR;
        end
      end
      ADDR: state_n = DATA;
      DATA: begin
        if (store_q) begin
          state_n = WRITE;
          wen_n   = 1'b1;
          wdata_n = merged;
        end else begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = load_val;
        end
      end
      WRITE: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        resp_rdata_n = '0;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      off_q      <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      sdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      d_addr     <= '0;
      wen        <= 1'b0;
      wdata      <= '0;
    end else begin
      state      <= state_n;
      off_q      <= off_n;
      funct3_q   <= funct3_n;
      store_q    <= store_n;
      sdata_q    <= sdata_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
      d_addr     <= d_addr_n;
      wen        <= wen_n;
      wdata      <= wdata_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table through a response/write scoreboard, plus busy-hold and mid-op reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] d_addr;
  logic [31:0] rdata = '0;
  logic        wen;
  logic [31:0] wdata;

  load_store_unit #(.WORD_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .d_addr(d_addr), .rdata(rdata), .wen(wen), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    logic        exp_wr;
    logic [31:0] exp_wa;
    logic [31:0] exp_wd;
    int          acc;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mem [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle synchronous memory, word-indexed
  always @(posedge clk) begin
    rdata <= mem[d_addr[9:2]];
    if (wen) mem[d_addr[9:2]] = wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wen) begin
      if (sbq.size() == 0 || !sbq[0].exp_wr) chk("wen_unexpected", {31'd0, wen}, 32'd0);
      else begin
        chk("wen_cycle", cyc - sbq[0].acc, sbq[0].lat - 1);
        chk("wr_addr", d_addr, sbq[0].exp_wa);
        chk("wr_data", wdata, sbq[0].exp_wd);
      end
    end
    if (resp_valid) begin
      if (sbq.size() == 0) chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
      else begin
        chk("resp_latency", cyc - sbq[0].acc, sbq[0].lat);
        chk("resp_err", {31'd0, resp_err}, {31'd0, sbq[0].exp_err});
        chk("resp_rdata", resp_rdata, sbq[0].exp_rd);
        void'(sbq.pop_front());
      end
    end
  end

  function automatic vec_t mk(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic e, int lat,
                              logic wr, logic [31:0] wa, logic [31:0] wwd);
    vec_t v;
    v.w = w; v.f3 = f3; v.addr = a; v.wd = wd; v.exp_rd = rd; v.exp_err = e;
    v.lat = lat; v.exp_wr = wr; v.exp_wa = wa; v.exp_wd = wwd; v.acc = 0;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (sbq.size() != 0) begin
      chk("resp_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic drive(input vec_t v);
    req_wen = v.w; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wd;
    req_valid = 1'b1;
  endtask

  task automatic send(input vec_t v, input int hold);
    vec_t s;
    wait_ready();
    s = v;
    s.acc = cyc;
    drive(v);
    sbq.push_back(s);
    repeat (hold) @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
  endtask

  localparam logic [31:0] ALT104 =
`ifdef LSU_MISALIGN_CHECK_EN
    32'h1234BEEF;
`else
    32'hCAFEF00D;
`endif

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = 32'h8899AABB;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_d_addr", d_addr, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(0, 3'd0, 32'h101, 0, 32'hFFFFFFAA, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd4, 32'h101, 0, 32'h000000AA, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd5, 32'h102, 0, 32'h00008899, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd1, 32'h102, 0, 32'hFFFF8899, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd2, 32'h100, 0, 32'h8899AABB, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 32'h103, 0, 32'hFFFFFF88, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd4, 32'h100, 0, 32'h000000BB, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 3'd0, 32'h102, 32'h00000012, 0, 0, 4, 1, 32'h100, 32'h8812AABB));
    tbl.push_back(mk(0, 3'd2, 32'h100, 0, 32'h8812AABB, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 0, 2, 1, 32'h104, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'd2, 32'h104, 0, 32'hDEADBEEF, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 3'd1, 32'h106, 32'hFFFF1234, 0, 0, 4, 1, 32'h104, 32'h1234BEEF));
    tbl.push_back(mk(0, 3'd2, 32'h104, 0, 32'h1234BEEF, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd3, 32'h100, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'd3, 32'h100, 32'h55, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd6, 32'h100, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd7, 32'h100, 0, 0, 1, 1, 0, 0, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    tbl.push_back(mk(0, 3'd1, 32'h101, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 3'd2, 32'h102, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h106, 32'hCAFEF00D, 0, 1, 1, 0, 0, 0));
`else
    tbl.push_back(mk(0, 3'd1, 32'h101, 0, 32'hFFFFAABB, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 3'd2, 32'h102, 0, 32'h8812AABB, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h106, 32'hCAFEF00D, 0, 0, 2, 1, 32'h104, 32'hCAFEF00D));
`endif
    tbl.push_back(mk(0, 3'd2, 32'h104, 0, ALT104, 0, 3, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) send(tbl[i], 1);

    // req_valid held through the whole busy window: exactly one response expected
    send(mk(0, 3'd2, 32'h104, 0, ALT104, 0, 3, 0, 0, 0), 4);
    repeat (3) @(posedge clk); #1;

    // SH interrupted by reset while in DATA: no write, no response
    wait_ready();
    drive(mk(1, 3'd1, 32'h100, 32'h00007777, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_wen", {31'd0, wen}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_mem", mem[64], 32'h8812AABB);
    send(mk(0, 3'd2, 32'h100, 0, 32'h8812AABB, 0, 3, 0, 0, 0), 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
